// File: rtl/cp2_dma_if.sv
// cp2_dma_if
// Bus bundle between the cp2_dma block feeder and the blocks it talks to.
// It carries two independent ports:
//   memory port : mem_req/mem_we/mem_addr/mem_wdata out of the feeder,
//                 mem_ack/mem_rdata back into it (read data valid with ack)
//   cptwo port  : cp_addr/cp_din/cp_we out of the feeder,
//                 cp_dout (combinational on cp_addr) and cp_int back into it
// Modports:
//   master : the cp2_dma side (drives requests and register accesses)
//   slave  : the memory / cptwo side (answers them)
interface cp2_dma_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic [3:0]        cp_addr;
    logic [31:0]       cp_din;
    logic              cp_we;
    logic [31:0]       cp_dout;
    logic              cp_int;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output cp_addr, cp_din, cp_we,
        input  cp_dout, cp_int
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  cp_addr, cp_din, cp_we,
        output cp_dout, cp_int
    );
endinterface

// File: rtl/cp2_dma.sv
// cp2_dma
// Block-streaming feeder for the cptwo AES coprocessor. For each 128-bit
// block it reads four words from memory, pushes them into cptwo's data-in
// register (13), writes the run command to the status register (0), waits
// for cp_int, pops the four result words from register 14 and writes them
// back to memory. Key and nonce are loaded by the CPU beforehand; this block
// never touches cptwo registers 1-12.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             one-cycle pulse, only honoured while idle
//   src_addr          byte address of the first plaintext word (word aligned)
//   dst_addr          byte address of the first result word (word aligned)
//   nblocks           number of 128-bit blocks to process
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle completion pulse
//   err               one-cycle pulse together with done on a timeout abort
//   bus (master)      memory request port and cptwo register port
//
// Optional feature macro: CP2_DMA_TIMEOUT_EN
//   When defined, WAIT_INT is bounded by TIMEOUT cycles; on expiry the
//   transfer is aborted with done and err. When undefined the block waits
//   for cp_int indefinitely and err is tied low.
module cp2_dma #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  nblocks,
    output logic              busy,
    output logic              done,
    output logic              err,
    cp2_dma_if.master         bus
);

    localparam logic [3:0]        CP_STATUS   = 4'd0;
    localparam logic [3:0]        CP_DATA_IN  = 4'd13;
    localparam logic [3:0]        CP_DATA_OUT = 4'd14;
    localparam logic [31:0]       CP_RUN_CMD  = 32'h0000_0001;
    localparam logic [ADDR_W-1:0] BLOCK_BYTES = ADDR_W'(16);

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        CP_WR,
        RUN,
        WAIT_INT,
        CP_RD,
        MEM_WR,
        DONE
    } state_t;

    state_t            state;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [1:0]        idx_q;
    logic [31:0]       blk_buf [4];

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        cp_addr_q;
    logic [31:0]       cp_din_q;
    logic              cp_we_q;

`ifdef CP2_DMA_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]  timer_q;
    logic              err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cp_addr   = cp_addr_q;
    assign bus.cp_din    = cp_din_q;
    assign bus.cp_we     = cp_we_q;

    // Byte offset of word i inside a block, zero-extended to the address width.
    function automatic logic [ADDR_W-1:0] word_off(input logic [1:0] i);
        logic [ADDR_W-1:0] off;
        off      = '0;
        off[3:0] = {i, 2'b00};
        return off;
    endfunction

    // Transfer sequencer. All bus outputs are registered: each transition
    // sets up the outputs the destination state presents, so the memory and
    // cptwo ports see clean, glitch-free values for the whole state. The
    // cptwo port is parked at address 0 with no write outside CP_WR, RUN
    // and CP_RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            idx_q       <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                blk_buf[k] <= '0;
            end
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cp_addr_q   <= 4'd0;
            cp_din_q    <= '0;
            cp_we_q     <= 1'b0;
`ifdef CP2_DMA_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (nblocks != '0) begin
                            src_q       <= src_addr;
                            dst_q       <= dst_addr;
                            remaining_q <= nblocks;
                            idx_q       <= 2'd0;
                            busy        <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= src_addr;
                            state       <= MEM_RD;
                        end else begin
                            // Empty transfer: straight to the done pulse.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                MEM_RD: begin
                    // The read word goes straight into the cptwo write data.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        cp_addr_q <= CP_DATA_IN;
                        cp_din_q  <= bus.mem_rdata;
                        cp_we_q   <= 1'b1;
                        state     <= CP_WR;
                    end
                end

                CP_WR: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cp_addr_q <= CP_STATUS;
                        cp_din_q  <= CP_RUN_CMD;
                        state     <= RUN;
                    end else begin
                        cp_addr_q  <= CP_STATUS;
                        cp_we_q    <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= src_q + word_off(idx_q + 2'd1);
                        state      <= MEM_RD;
                    end
                end

                RUN: begin
                    cp_we_q  <= 1'b0;
                    cp_din_q <= '0;
`ifdef CP2_DMA_TIMEOUT_EN
                    timer_q  <= TMR_W'(TIMEOUT);
`endif
                    state    <= WAIT_INT;
                end

                WAIT_INT: begin
                    // cp_int is checked first so that an interrupt arriving
                    // in the expiry cycle still completes normally.
                    if (bus.cp_int) begin
                        cp_addr_q <= CP_DATA_OUT;
                        idx_q     <= 2'd0;
                        state     <= CP_RD;
                    end
`ifdef CP2_DMA_TIMEOUT_EN
                    else if (timer_q == TMR_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
`endif
                end

                CP_RD: begin
                    // cptwo pops one word per edge while address 14 is held,
                    // so this state lasts exactly four cycles.
                    blk_buf[idx_q] <= bus.cp_dout;
                    idx_q          <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cp_addr_q   <= CP_STATUS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= dst_q;
                        mem_wdata_q <= blk_buf[0];
                        state       <= MEM_WR;
                    end
                end

                MEM_WR: begin
                    if (bus.mem_ack) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            src_q       <= src_q + BLOCK_BYTES;
                            dst_q       <= dst_q + BLOCK_BYTES;
                            remaining_q <= remaining_q - CNT_W'(1);
                            mem_we_q    <= 1'b0;
                            if (remaining_q == CNT_W'(1)) begin
                                mem_req_q <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end else begin
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= src_q + BLOCK_BYTES;
                                state      <= MEM_RD;
                            end
                        end else begin
                            mem_addr_q  <= dst_q + word_off(idx_q + 2'd1);
                            mem_wdata_q <= blk_buf[idx_q + 2'd1];
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
`ifdef CP2_DMA_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cp2_dma.md
Name: cp2_dma

Overview:
- Block-streaming DMA feeder that sits directly upstream of the cptwo AES coprocessor and owns its register port while busy.
- For each 128-bit block it:
  - reads 4 words from memory,
  - pushes them into cptwo's data-in register (addr 13),
  - writes run to the status register (addr 0),
  - waits for cp_int,
  - drains the 4 result words from addr 14,
  - writes them back to memory.
- Key and nonce are loaded by the CPU before start. cp2_dma never touches addrs 1-12.

Parameters:
- ADDR_W, 32, byte-address width of memory port.
- CNT_W, 16, width of block-count input.
- TIMEOUT, 4096, cycles allowed in WAIT_INT (used only with CP2_DMA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- src_addr  in  ADDR_W  byte address of first plaintext word; word aligned
- dst_addr  in  ADDR_W  byte address of first result word; word aligned
- nblocks  in  CNT_W  number of 128-bit blocks
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse with done on timeout abort
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req
- mem_addr  out  ADDR_W  request address; stable while mem_req
- mem_wdata  out  32  write data; stable while mem_req
- mem_ack  in  1  request accepted; for reads, mem_rdata is valid this cycle
- mem_rdata  in  32  read data
- cp_addr  out  4  cptwo register address
- cp_din  out  32  cptwo write data
- cp_we  out  1  cptwo write enable
- cp_dout  in  32  cptwo read data (combinational on cp_addr)
- cp_int  in  1  cptwo completion interrupt

Behaviour:
- Reset values (async, immediate on rst; also reset mid-transfer): state IDLE; busy, done, err, mem_req, mem_we, cp_we = 0; mem_addr, mem_wdata, cp_din = 0; cp_addr = 0; word index and block counter = 0. Any in-flight memory request is dropped; the memory side must tolerate this.
- Idle parking: cp_addr = 0 with cp_we = 0 whenever not in CP_WR, RUN or CP_RD. Status reads have no side effects.
- FSM states: IDLE, MEM_RD, CP_WR, RUN, WAIT_INT, CP_RD, MEM_WR, DONE.
- IDLE:
  - start=1 and nblocks!=0: latch src/dst/nblocks, clear word index, go to MEM_RD, busy=1.
  - start=1 and nblocks==0: go to DONE (done pulse the next cycle; no bus traffic).
- MEM_RD: mem_req=1, mem_we=0, mem_addr=src+4*i. On mem_ack, capture mem_rdata and go to CP_WR.
- CP_WR: exactly one cycle with cp_addr=13, cp_din=captured word, cp_we=1. Then i++. If i was 3, go to RUN; otherwise go to MEM_RD.
- RUN: one cycle with cp_addr=0, cp_din=32'h00000001, cp_we=1. Then go to WAIT_INT.
- WAIT_INT: cp_we=0, cp_addr=0. Leave when cp_int=1; go to CP_RD with i=0.
- CP_RD: cp_addr=14, cp_we=0 for exactly 4 consecutive cycles. cptwo pops one output word per rising edge with addr==14 and we==0. cp_dout is captured into a 4x32 buffer slot i on each edge. After the 4th capture, go to MEM_WR with i=0.
- MEM_WR: mem_req=1, mem_we=1, mem_addr=dst+4*i, mem_wdata=buf[i]. On mem_ack, i++. After word 3: src+=16, dst+=16, decrement remaining.
  - remaining==0: go to DONE.
  - else: go to MEM_RD.
- DONE: done=1 for one cycle; busy drops the same cycle; return to IDLE.
- Word order: word 0 is bits [31:0] of the block, at the lowest address.
- Latency with mem_ack in the first request cycle: 2 cycles per input word, RUN 1, 4 CP_RD, 1 per output word.
- Minimum per-block overhead is 17 cycles plus the cptwo compute time.
- start while busy is ignored. The cp_int level is not re-checked outside WAIT_INT.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
CP2_DMA_TIMEOUT_EN
- Defined: a down-counter loads TIMEOUT on entry to WAIT_INT and decrements each cycle. On reaching 0 without cp_int:
  - abort to DONE with done=1 and err=1 together;
  - skip remaining blocks;
  - no CP_RD and no memory writes for the aborted block.
  - cp_int in the same cycle as expiry wins (no error).
- Not defined: no counter; WAIT_INT waits indefinitely; err tied to 0.

Test Plan:
- Single block: CPU preloads KEY = 256'hFF..FF and NONCE = 0; memory src holds FFFFFFFF x4; nblocks=1. Expect dst words [31:0]..[127:96] of 128'hD5F93D6D3311CB309F23621B02FBD5E2 and exactly one done pulse.
- Round trip: nblocks=1, with src = the ciphertext result from the first test. Expect dst = FFFFFFFF x4.
- Multi-block with memory wait states: nblocks=3, mem_ack delayed 0-3 random cycles. Expect:
  - 12 reads at src+0..src+44 and 12 writes at dst+0..dst+44, in order;
  - mem_addr and mem_wdata stable while mem_req is high.
- nblocks=0: start → done one cycle later; mem_req, cp_we and err never asserted.
- Reset mid-operation: assert rst during WAIT_INT of block 2 of 3. Expect all outputs 0 immediately; a subsequent start with nblocks=1 completes correctly.
- With CP2_DMA_TIMEOUT_EN and TIMEOUT=16: cp_int held low. Expect done=err=1 exactly 16 cycles after entering WAIT_INT, and zero memory writes.
